// File: rtl/split4.sv
// split4: serialises each accepted 32-bit word into byte beats, LSB first, with an optional checksum beat (SPLIT4_CHECKSUM_EN)
module split4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        valid_a,
  output logic        ready_a,
  output logic        valid_b,
  input  logic        ready_b,
  output logic [7:0]  data_out,
  output logic        last_b
);
`ifdef SPLIT4_CHECKSUM_EN
  localparam int IW = 3;
  localparam logic [IW-1:0] LAST_IDX = 3'd4;
`else
  localparam int IW = 2;
  localparam logic [IW-1:0] LAST_IDX = 2'd3;
`endif
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [31:0] word;
  logic [IW-1:0] idx;
  logic [7:0] beat;
  logic up_xfer, dn_xfer;
  assign up_xfer = valid_a && ready_a;
  assign dn_xfer = valid_b && ready_b;
  assign beat = word[{idx[1:0], 3'b000} +: 8];
`ifdef SPLIT4_CHECKSUM_EN
  logic [7:0] sum;
  assign sum = word[7:0] + word[15:8] + word[23:16] + word[31:24];
`endif
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // a new word keeps us in SEND even when the last beat leaves on the same edge
  always_comb begin
    state_nxt = up_xfer ? SEND : (dn_xfer && last_b) ? IDLE : state;
  end
  // handshake and beat outputs; ready_a looks through to ready_b on the final beat
  always_comb begin
    valid_b = state == SEND;
    last_b = valid_b && idx == LAST_IDX;
    ready_a = rst_n && (state == IDLE || (ready_b && last_b));
`ifdef SPLIT4_CHECKSUM_EN
    data_out = !valid_b ? 8'h00 : idx == LAST_IDX ? sum : beat;
`else
    data_out = valid_b ? beat : 8'h00;
`endif
  end
  // held word and beat index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word <= '0;
      idx <= '0;
    end else if (up_xfer) begin
      word <= data_in;
      idx <= '0;
    end else if (dn_xfer) begin
      idx <= last_b ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_split4.sv
// tb_split4: directed vector table, reset-mid-word sequence and randomized run against a byte-queue model
module tb_split4;
  logic clk = 1'b0;
  logic rst_n, valid_a, ready_a, valid_b, ready_b, last_b;
  logic [31:0] data_in;
  logic [7:0] data_out;
  int checks = 0;
  int errors = 0;

  split4 dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_a(valid_a), .ready_a(ready_a),
    .valid_b(valid_b), .ready_b(ready_b), .data_out(data_out), .last_b(last_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic va;
    logic [31:0] din;
    logic rb;
    logic ra;
    logic vb;
    logic [7:0] d;
    logic l;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic va, logic [31:0] din, logic rb,
                              logic ra, logic vb, logic [7:0] d, logic l);
    vec_t v;
    v.rst = rst; v.va = va; v.din = din; v.rb = rb;
    v.ra = ra; v.vb = vb; v.d = d; v.l = l;
    return v;
  endfunction

  function automatic logic [7:0] csum(logic [31:0] w);
    return w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction

  // final data beat of a word, followed by the checksum beat when enabled
  task automatic push_last(logic va, logic [31:0] din, logic [7:0] b3, logic [7:0] ck);
`ifdef SPLIT4_CHECKSUM_EN
    tbl.push_back(mk(1, va, din, 1, 0, 1, b3, 0));
    tbl.push_back(mk(1, va, din, 1, 1, 1, ck, 1));
`else
    tbl.push_back(mk(1, va, din, 1, 1, 1, b3, 1));
    if (ck == 8'hxx) $display("unreachable");
`endif
  endtask

  task automatic apply(logic r, logic va, logic [31:0] d, logic rb);
    rst_n = r; valid_a = va; data_in = d; ready_b = rb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic ra, logic vb, logic [7:0] d, logic l);
    checks++;
    if ({ready_a, valid_b, data_out, last_b} !== {ra, vb, d, l}) begin
      errors++;
      $display("FAIL %s: got ra=%0b vb=%0b d=%02h last=%0b, expected ra=%0b vb=%0b d=%02h last=%0b",
               nm, ready_a, valid_b, data_out, last_b, ra, vb, d, l);
    end
  endtask

  logic [7:0] q[$];
  logic [7:0] seq[$];

  initial begin
    apply(0, 0, 0, 1);
    tick();
    tick();
    // reset state
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 0));
    // single word, full-rate drain; accepted on first edge out of reset
    tbl.push_back(mk(1, 1, 32'h04030201, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 8'h01, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 8'h02, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 8'h03, 0));
    push_last(0, 0, 8'h04, 8'h0A);
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 8'h00, 0));
    // stall on byte1 for three cycles while an ignored word is offered
    tbl.push_back(mk(1, 1, 32'h04030201, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 8'h01, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 32'hDEADBEEF, 0, 0, 1, 8'h02, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 8'h02, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 8'h03, 0));
    push_last(0, 0, 8'h04, 8'h0A);
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 8'h00, 0));
    // back-to-back words with valid_a held
    tbl.push_back(mk(1, 1, 32'h44332211, 1, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 32'h88776655, 1, 0, 1, 8'h11, 0));
    tbl.push_back(mk(1, 1, 32'h88776655, 1, 0, 1, 8'h22, 0));
    tbl.push_back(mk(1, 1, 32'h88776655, 1, 0, 1, 8'h33, 0));
    push_last(1, 32'h88776655, 8'h44, 8'hAA);
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 8'h55, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 8'h66, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 8'h77, 0));
    push_last(0, 0, 8'h88, 8'hBA);
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 8'h00, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].va, tbl[i].din, tbl[i].rb);
      chk($sformatf("vec%0d", i), tbl[i].ra, tbl[i].vb, tbl[i].d, tbl[i].l);
      tick();
    end

    // reset after byte1 has transferred discards the rest of the word
    apply(1, 1, 32'h04030201, 1);
    chk("rst_accept", 1, 0, 8'h00, 0);
    tick();
    apply(1, 0, 0, 1);
    chk("rst_b0", 0, 1, 8'h01, 0);
    tick();
    chk("rst_b1", 0, 1, 8'h02, 0);
    tick();
    apply(0, 1, 32'h12345678, 1);
    chk("rst_low", 0, 1, 8'h03, 0);
    tick();
    apply(1, 0, 0, 1);
    chk("rst_after", 1, 0, 8'h00, 0);
    apply(1, 1, 32'h000000FF, 1);
    tick();
    apply(1, 0, 0, 1);
    seq = '{8'hFF, 8'h00, 8'h00, 8'h00};
`ifdef SPLIT4_CHECKSUM_EN
    seq.push_back(8'hFF);
`endif
    for (int i = 0; i < seq.size(); i++) begin
      chk($sformatf("rst_new%0d", i), i == seq.size() - 1, 1, seq[i], i == seq.size() - 1);
      tick();
    end
    chk("rst_idle", 1, 0, 8'h00, 0);

    // randomized traffic against a queue-of-pending-beats model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic r, va, rb, evb, el, era;
      logic [31:0] d;
      logic [7:0] ed;
      r = $urandom_range(0, 63) != 0;
      va = $urandom_range(0, 2) != 0;
      rb = $urandom_range(0, 3) != 0;
      d = $urandom;
      apply(r, va, d, rb);
      evb = q.size() != 0;
      ed = evb ? q[0] : 8'h00;
      el = q.size() == 1;
      era = r && (!evb || (rb && el));
      chk($sformatf("rand%0d", c), era, evb, ed, el);
      if (!r) q.delete();
      else begin
        if (evb && rb) void'(q.pop_front());
        if (era && va) begin
          for (int i = 0; i < 4; i++) q.push_back(d[8*i +: 8]);
`ifdef SPLIT4_CHECKSUM_EN
          q.push_back(csum(d));
`endif
        end
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
